// File: rtl/control_unwinder_pkg.sv
// rtl/control_unwinder_pkg.sv - shared frame layout, frame types and unwinder states
package control_unwinder_pkg;

    localparam int CS_WIDTH_DEF = 15;
    localparam int DEPTH_W_DEF  = 5;
    localparam int ADDR_W_DEF   = 8;
    localparam int SP_TAG_W_DEF = 4;

    // Control-stack frame kinds, stored in the two top bits of a frame
    typedef enum logic [1:0] {
        FRAME_BLOCK = 2'b00,
        FRAME_CALL  = 2'b01,
        FRAME_IF    = 2'b10,
        FRAME_LOOP  = 2'b11
    } frame_type_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_UNWIND = 3'd1,
        ST_TARGET = 3'd2,
        ST_RET    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/control_unwinder_cs_frame_decode.sv
// rtl/control_unwinder_cs_frame_decode.sv - splits a control-stack frame into its fields
module cs_frame_decode
    import control_unwinder_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int SP_TAG_W = SP_TAG_W_DEF,
    parameter int CS_WIDTH = ADDR_W + SP_TAG_W + 3
) (
    input  logic [CS_WIDTH-1:0] frame,
    output frame_type_t         f_type,
    output logic                f_retu,
    output logic [SP_TAG_W-1:0] f_sp_tag,
    output logic [ADDR_W-1:0]   f_addr
);

    // Layout from MSB: type[1:0], retu_num, sp_tag, ret_addr
    assign f_type   = frame_type_t'(frame[CS_WIDTH-1 -: 2]);
    assign f_retu   = frame[CS_WIDTH-3];
    assign f_sp_tag = frame[ADDR_W +: SP_TAG_W];
    assign f_addr   = frame[ADDR_W-1:0];

endmodule

// File: rtl/control_unwinder.sv
// rtl/control_unwinder.sv - executes end / br N / return by popping the control stack
module control_unwinder
    import control_unwinder_pkg::*;
#(
    parameter int CS_WIDTH = CS_WIDTH_DEF,
    parameter int DEPTH_W  = DEPTH_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int SP_TAG_W = SP_TAG_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                end_req,
    input  logic                br_req,
    input  logic [DEPTH_W-1:0]  br_depth,
    input  logic                ret_req,
    output logic                busy,
    input  logic [CS_WIDTH-1:0] cs_top_data,
    input  logic                cs_left_one,
    output logic                cs_pop,
    output logic                cs_retu,
    output logic                done,
    output logic                jump_valid,
    output logic [ADDR_W-1:0]   jump_addr,
    output logic                seek_end,
    output logic [SP_TAG_W-1:0] restore_sp_tag,
    output logic                keep_result,
    output logic                err
);

    state_t               state, state_nxt;
    logic [DEPTH_W-1:0]   cnt, cnt_nxt;
    logic                 force_pop, force_pop_nxt;
    logic                 jv_nxt, seek_nxt, keep_nxt, err_nxt;
    logic [ADDR_W-1:0]    addr_nxt;
    logic [SP_TAG_W-1:0]  tag_nxt;

    frame_type_t          f_type;
    logic                 f_retu;
    logic [SP_TAG_W-1:0]  f_sp_tag;
    logic [ADDR_W-1:0]    f_addr;

    cs_frame_decode #(
        .ADDR_W   (ADDR_W),
        .SP_TAG_W (SP_TAG_W),
        .CS_WIDTH (CS_WIDTH)
    ) u_decode (
        .frame    (cs_top_data),
        .f_type   (f_type),
        .f_retu   (f_retu),
        .f_sp_tag (f_sp_tag),
        .f_addr   (f_addr)
    );

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    // State, remaining-depth counter and the registered result fields
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            force_pop      <= 1'b0;
            jump_valid     <= 1'b0;
            jump_addr      <= '0;
            seek_end       <= 1'b0;
            restore_sp_tag <= '0;
            keep_result    <= 1'b0;
            err            <= 1'b0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            force_pop      <= force_pop_nxt;
            jump_valid     <= jv_nxt;
            jump_addr      <= addr_nxt;
            seek_end       <= seek_nxt;
            restore_sp_tag <= tag_nxt;
            keep_result    <= keep_nxt;
            err            <= err_nxt;
        end
    end

    // Next state, pop strobes and result capture from the frame on top of the stack
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        force_pop_nxt = force_pop;
        cs_pop        = 1'b0;
        cs_retu       = 1'b0;
        jv_nxt        = jump_valid;
        addr_nxt      = jump_addr;
        seek_nxt      = seek_end;
        tag_nxt       = restore_sp_tag;
        keep_nxt      = keep_result;
        err_nxt       = err;
        case (state)
            ST_IDLE: begin
                if (ret_req || br_req || end_req) begin
                    // Results of the previous unwind are dropped on accept
                    jv_nxt   = 1'b0;
                    addr_nxt = '0;
                    seek_nxt = 1'b0;
                    tag_nxt  = '0;
                    keep_nxt = 1'b0;
                    err_nxt  = 1'b0;
                    if (ret_req) begin
                        state_nxt = ST_RET;
                    end else if (br_req) begin
                        cnt_nxt       = br_depth;
                        force_pop_nxt = 1'b0;
                        state_nxt     = (br_depth == '0) ? ST_TARGET : ST_UNWIND;
                    end else begin
                        force_pop_nxt = 1'b1;
                        state_nxt     = ST_TARGET;
                    end
                end
            end
            ST_UNWIND: begin
                // A call frame may not be crossed, and the last frame must not be popped early
                if (f_type == FRAME_CALL || (cs_left_one && cnt > DEPTH_W'(1))) begin
                    err_nxt   = 1'b1;
                    jv_nxt    = 1'b0;
                    seek_nxt  = 1'b0;
                    state_nxt = ST_DONE;
                end else begin
                    cs_pop = 1'b1;
                    if (cnt == DEPTH_W'(1)) begin
                        state_nxt = ST_TARGET;
                    end else begin
                        cnt_nxt = cnt - DEPTH_W'(1);
                    end
                end
            end
            ST_TARGET: begin
                tag_nxt   = f_sp_tag;
                keep_nxt  = f_retu;
                state_nxt = ST_DONE;
                if (force_pop) begin
                    cs_pop = 1'b1;
                    if (f_type == FRAME_CALL) begin
                        jv_nxt   = 1'b1;
                        addr_nxt = f_addr;
                    end
                end else begin
                    case (f_type)
                        FRAME_LOOP: begin
                            // Loop label: branch back to the loop start, frame stays live
                            jv_nxt   = 1'b1;
                            addr_nxt = f_addr;
                        end
                        FRAME_CALL: begin
                            cs_pop   = 1'b1;
                            jv_nxt   = 1'b1;
                            addr_nxt = f_addr;
                        end
                        default: begin
                            cs_pop   = 1'b1;
                            seek_nxt = 1'b1;
                        end
                    endcase
                end
            end
            ST_RET: begin
                cs_pop    = 1'b1;
                cs_retu   = 1'b1;
                jv_nxt    = 1'b1;
                addr_nxt  = f_addr;
                tag_nxt   = f_sp_tag;
                keep_nxt  = f_retu;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
